// File: rtl/gmii_pkg.sv
// gmii_pkg: shared GMII framer constants, state encoding and CRC-32 byte step
package gmii_pkg;
  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_SFD = 8'hD5;
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_ABORT, S_DRAIN, S_IPG
  } state_t;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC32_POLY : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/gmii_crc32.sv
// gmii_crc32: registered reflected CRC-32 accumulator, one byte per enabled cycle
module gmii_crc32
  import gmii_pkg::*;
(
  input  logic        rx_clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);
  always_ff @(posedge rx_clk)
    crc <= (reset || init) ? CRC32_INIT : en ? crc32_byte(crc, data) : crc;
endmodule

// File: rtl/gmii_framer.sv
// gmii_framer: byte stream to GMII frames with preamble, SFD, padding, FCS and inter-packet gap
module gmii_framer
  import gmii_pkg::*;
#(
  parameter int PRE_LEN = 7,
  parameter int IPG_LEN = 12,
  parameter int MIN_LEN = 60,
  parameter int PAD_EN  = 1,
  parameter int FCS_EN  = 1,
  parameter int CNT_W   = 32
) (
  input  logic             rx_clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [7:0]       c_data,
  input  logic             c_eop,
  output logic [7:0]       rxd,
  output logic             rx_dv,
  output logic             rx_er,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] underrun_cnt
);
  localparam logic [15:0] PRE_LAST = 16'(PRE_LEN - 1);
  localparam logic [15:0] IPG_LAST = 16'(IPG_LEN - 1);
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam state_t END_ST = (FCS_EN != 0) ? S_FCS : S_IPG;
  state_t state;
  logic [15:0] cnt, len, len_nx;
  logic [31:0] crc;
  logic [7:0] fcs_byte;
  logic crc_en, pad_go, pad_done;
  always_comb begin
    c_drdy = state == S_DATA || state == S_DRAIN;
    busy = state != S_IDLE;
    len_nx = &len ? len : len + 16'd1;
    pad_go = PAD_EN != 0 && len_nx < MIN_L;
    pad_done = len_nx >= MIN_L;
    crc_en = (state == S_DATA && c_srdy) || state == S_PAD;
    fcs_byte = 8'(~crc >> {cnt[1:0], 3'b000});
  end
  gmii_crc32 u_crc (
    .rx_clk(rx_clk),
    .reset(reset),
    .init(state == S_IDLE),
    .en(crc_en),
    .data(state == S_PAD ? 8'h00 : c_data),
    .crc(crc)
  );
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      len <= '0;
      rxd <= '0;
      rx_dv <= 1'b0;
      rx_er <= 1'b0;
      frame_cnt <= '0;
      underrun_cnt <= '0;
    end else begin
      rxd <= '0;
      rx_dv <= 1'b0;
      rx_er <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          len <= '0;
          if (c_srdy) state <= S_PRE;
        end
        S_PRE: begin
          rxd <= GMII_PREAMBLE;
          rx_dv <= 1'b1;
          cnt <= cnt == PRE_LAST ? '0 : cnt + 16'd1;
          if (cnt == PRE_LAST) state <= S_SFD;
        end
        S_SFD: begin
          rxd <= GMII_SFD;
          rx_dv <= 1'b1;
          state <= S_DATA;
        end
        S_DATA: begin
          rx_dv <= 1'b1;
          cnt <= '0;
          if (c_srdy) begin
            rxd <= c_data;
            len <= len_nx;
            if (c_eop) begin
              state <= pad_go ? S_PAD : END_ST;
              if (!pad_go && FCS_EN == 0) frame_cnt <= frame_cnt + ONE;
            end
          end else begin
            rx_er <= 1'b1;
            underrun_cnt <= underrun_cnt + ONE;
            state <= S_ABORT;
          end
        end
        S_PAD: begin
          rx_dv <= 1'b1;
          len <= len_nx;
          if (pad_done) begin
            state <= END_ST;
            if (FCS_EN == 0) frame_cnt <= frame_cnt + ONE;
          end
        end
        S_FCS: begin
          rxd <= fcs_byte;
          rx_dv <= 1'b1;
          cnt <= cnt[1:0] == 2'd3 ? '0 : cnt + 16'd1;
          if (cnt[1:0] == 2'd3) begin
            state <= S_IPG;
            frame_cnt <= frame_cnt + ONE;
          end
        end
        S_ABORT: state <= S_DRAIN;
        S_DRAIN: begin
          cnt <= '0;
          if (c_srdy && c_eop) state <= S_IPG;
        end
        S_IPG: begin
          cnt <= cnt + 16'd1;
          if (cnt == IPG_LAST) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
